// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto one single-ported memory, one transaction in flight
// Optional fetch anti-starvation counter enabled by defining ARB_FAIR_EN.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int FETCH_MAX_WAIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [2:0]            d_size,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  m_req,
   output logic                  m_we,
   output logic [2:0]            m_size,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   input  logic                  m_ready,
   input  logic                  m_rvalid,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   output logic                  proto_err
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  m_req_q, m_req_d;
   logic                  m_we_q, m_we_d;
   logic [2:0]            m_size_q, m_size_d;
   logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
   logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
   logic                  i_rvalid_q, i_rvalid_d;
   logic                  d_rvalid_q, d_rvalid_d;
   logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic                  proto_err_q, proto_err_d;
   logic                  arb_open;
   logic                  fetch_win;
   logic                  fetch_boost;
   logic                  i_gnt_c;
   logic                  d_gnt_c;

`ifdef ARB_FAIR_EN
   localparam int CW = $clog2(FETCH_MAX_WAIT + 1);
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;

   assign fetch_boost = (wait_cnt_q == CW'(FETCH_MAX_WAIT));

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (i_gnt_c) begin
         wait_cnt_d = '0;
      end else if (i_req && !fetch_boost) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`else
   assign fetch_boost = 1'b0;
`endif

   // Data normally wins: the load/store is older in program order than the fetch.
   assign fetch_win = i_req && (!d_req || fetch_boost);

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      m_req_d     = m_req_q;
      m_we_d      = m_we_q;
      m_size_d    = m_size_q;
      m_addr_d    = m_addr_q;
      m_wdata_d   = m_wdata_q;
      i_rvalid_d  = 1'b0;
      d_rvalid_d  = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      proto_err_d = proto_err_q | (m_rvalid && (state_q != S_WAIT));
      arb_open    = 1'b0;

      case (state_q)
         S_IDLE: begin
            arb_open = 1'b1;
         end
         S_ISSUE: begin
            if (m_ready) begin
               m_req_d = 1'b0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (m_rvalid) begin
               arb_open = 1'b1;
               state_d  = S_IDLE;
               if (owner_q) begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = m_rdata;
               end else begin
                  i_rvalid_d = 1'b1;
                  i_rdata_d  = m_rdata;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Gated by rst_n so the combinational grants also read 0 while reset is held.
      i_gnt_c = rst_n && arb_open && fetch_win;
      d_gnt_c = rst_n && arb_open && d_req && !fetch_win;

      if (i_gnt_c) begin
         owner_d   = 1'b0;
         m_req_d   = 1'b1;
         m_we_d    = 1'b0;
         m_size_d  = 3'b010;
         m_addr_d  = i_addr;
         m_wdata_d = '0;
         state_d   = S_ISSUE;
      end else if (d_gnt_c) begin
         owner_d   = 1'b1;
         m_req_d   = 1'b1;
         m_we_d    = d_we;
         m_size_d  = d_size;
         m_addr_d  = d_addr;
         m_wdata_d = d_wdata;
         state_d   = S_ISSUE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         m_req_q     <= 1'b0;
         m_we_q      <= 1'b0;
         m_size_q    <= 3'b000;
         m_addr_q    <= '0;
         m_wdata_q   <= '0;
         i_rvalid_q  <= 1'b0;
         d_rvalid_q  <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         m_req_q     <= m_req_d;
         m_we_q      <= m_we_d;
         m_size_q    <= m_size_d;
         m_addr_q    <= m_addr_d;
         m_wdata_q   <= m_wdata_d;
         i_rvalid_q  <= i_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign i_gnt     = i_gnt_c;
   assign d_gnt     = d_gnt_c;
   assign i_rvalid  = i_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign m_req     = m_req_q;
   assign m_we      = m_we_q;
   assign m_size    = m_size_q;
   assign m_addr    = m_addr_q;
   assign m_wdata   = m_wdata_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_gnt, i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [2:0]  d_size = '0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        m_req, m_we;
   logic [2:0]  m_size;
   logic [31:0] m_addr, m_wdata;
   logic        m_ready = 1'b0;
   logic        m_rvalid = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        proto_err;

   int checks = 0;
   int errors = 0;

   // model: one transaction record plus the values the outputs should show
   logic        t_busy, t_acc, t_data;
   logic        c_we;
   logic [2:0]  c_size;
   logic [31:0] c_addr, c_wdata;
   logic        e_irv, e_drv, e_perr;
   logic [31:0] e_ird, e_drd;
   int          starve;
   logic        last_ig, last_dg;

   logic        s_i_gnt, s_d_gnt, s_i_rvalid, s_d_rvalid, s_m_req, s_m_we, s_perr;
   logic [2:0]  s_m_size;
   logic [31:0] s_i_rdata, s_d_rdata, s_m_addr, s_m_wdata;

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FETCH_MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mdl_reset();
      t_busy = 0; t_acc = 0; t_data = 0;
      c_we = 0; c_size = '0; c_addr = '0; c_wdata = '0;
      e_irv = 0; e_drv = 0; e_perr = 0; e_ird = '0; e_drd = '0;
      starve = 0; last_ig = 0; last_dg = 0;
   endtask

   // Entered just after a rising edge with inputs applied; compares at the falling edge.
   task automatic cyc();
      logic resp, open_, ff, eg_i, eg_d, boost;
      @(negedge clk);
      s_i_gnt = i_gnt; s_d_gnt = d_gnt; s_i_rvalid = i_rvalid; s_d_rvalid = d_rvalid;
      s_i_rdata = i_rdata; s_d_rdata = d_rdata; s_m_req = m_req; s_m_we = m_we;
      s_m_size = m_size; s_m_addr = m_addr; s_m_wdata = m_wdata; s_perr = proto_err;
      if (!rst_n) begin
         mdl_reset();
         eg_i = 0; eg_d = 0;
      end else begin
         resp  = t_busy && t_acc && m_rvalid;
         open_ = !t_busy || resp;
`ifdef ARB_FAIR_EN
         boost = (starve >= MAXW);
`else
         boost = 1'b0;
`endif
         ff   = i_req && (!d_req || boost);
         eg_i = open_ && ff;
         eg_d = open_ && d_req && !ff;
      end
      chk("i_gnt", s_i_gnt, eg_i);
      chk("d_gnt", s_d_gnt, eg_d);
      chk("i_rvalid", s_i_rvalid, e_irv);
      chk("d_rvalid", s_d_rvalid, e_drv);
      chk("i_rdata", s_i_rdata, e_ird);
      chk("d_rdata", s_d_rdata, e_drd);
      chk("m_req", s_m_req, t_busy && !t_acc);
      chk("m_we", s_m_we, c_we);
      chk("m_size", s_m_size, c_size);
      chk("m_addr", s_m_addr, c_addr);
      chk("m_wdata", s_m_wdata, c_wdata);
      chk("proto_err", s_perr, e_perr);
      chk("rvalid_excl", s_i_rvalid & s_d_rvalid, 0);
      if (rst_n) begin
         e_irv = resp && !t_data;
         e_drv = resp && t_data;
         if (resp && t_data) e_drd = m_rdata;
         if (resp && !t_data) e_ird = m_rdata;
         if (m_rvalid && !(t_busy && t_acc)) e_perr = 1;
         if (t_busy && !t_acc && m_ready) t_acc = 1;
         if (resp) t_busy = 0;
         if (eg_i || eg_d) begin
            t_busy = 1; t_acc = 0; t_data = eg_d;
            c_we    = eg_d ? d_we : 1'b0;
            c_size  = eg_d ? d_size : 3'b010;
            c_addr  = eg_d ? d_addr : i_addr;
            c_wdata = eg_d ? d_wdata : 32'h0;
         end
         if (eg_i) starve = 0;
         else if (i_req && starve < MAXW) starve++;
         last_ig = eg_i; last_dg = eg_d;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      m_ready = 1;
      while ((t_busy || i_req || d_req) && n < 40) begin
         if (last_ig) i_req = 0;
         if (last_dg) d_req = 0;
         m_rvalid = t_busy && t_acc;
         m_rdata  = $urandom;
         cyc();
         n++;
      end
      m_rvalid = 0;
      chk("drain_timeout", n < 40, 1);
   endtask

   initial begin
      int igr, refused;
      mdl_reset();
      i_req = 1; d_req = 1; d_addr = 32'h40;
      @(posedge clk); #1;
      cyc();
      cyc();
      chk("reset_i_gnt_gated", s_i_gnt, 0);
      chk("reset_m_req", s_m_req, 0);
      i_req = 0; d_req = 0; rst_n = 1;

      // 1: fetch only, minimum latency
      i_req = 1; i_addr = 32'h100; m_ready = 1;
      cyc();
      chk("t1_gnt", s_i_gnt, 1);
      i_req = 0;
      cyc();
      chk("t1_m_addr", s_m_addr, 32'h100);
      chk("t1_m_size", s_m_size, 3'b010);
      m_rvalid = 1; m_rdata = 32'h00A00093;
      cyc();
      chk("t1_early_rvalid", s_i_rvalid, 0);
      m_rvalid = 0;
      cyc();
      chk("t1_rvalid", s_i_rvalid, 1);
      chk("t1_rdata", s_i_rdata, 32'h00A00093);
      cyc();
      chk("t1_pulse", s_i_rvalid, 0);

      // 2: simultaneous store and fetch
      d_req = 1; d_we = 1; d_addr = 32'h2000; d_size = 3'b000; d_wdata = 32'hFF;
      i_req = 1; i_addr = 32'h104;
      cyc();
      chk("t2_d_first", s_d_gnt, 1);
      chk("t2_i_wait", s_i_gnt, 0);
      d_req = 0;
      cyc();
      chk("t2_m_we", s_m_we, 1);
      chk("t2_m_size", s_m_size, 3'b000);
      chk("t2_m_wdata", s_m_wdata, 32'hFF);
      m_rvalid = 1; m_rdata = 32'h1234;
      cyc();
      chk("t2_i_gnt_on_resp", s_i_gnt, 1);
      i_req = 0; m_rvalid = 0;
      cyc();
      chk("t2_store_done", s_d_rvalid, 1);
      chk("t2_no_i_rvalid", s_i_rvalid, 0);
      chk("t2_fetch_issue", s_m_addr, 32'h104);
      drain();

      // 3: memory stalls for 5 cycles with a fetch pending
      d_req = 1; d_we = 0; d_size = 3'b010; d_addr = 32'h3000; m_ready = 0;
      cyc();
      d_req = 0; i_req = 1; i_addr = 32'h108;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("t3_m_req_held", s_m_req, 1);
         chk("t3_m_addr_held", s_m_addr, 32'h3000);
         chk("t3_no_gnt", s_i_gnt, 0);
      end
      drain();

      // 4: data held continuously against a waiting fetch
      d_req = 1; d_we = 0; d_size = 3'b010; i_req = 1; i_addr = 32'h10C; m_ready = 1;
      igr = 0; refused = 0;
      for (int k = 0; k < 20; k++) begin
         d_addr = 32'h4000 + 32'(k * 4);
         m_rvalid = t_busy && t_acc;
         cyc();
         if (s_i_gnt) begin
            igr++;
            i_req = 0;
         end else if (igr == 0) refused++;
      end
`ifdef ARB_FAIR_EN
      chk("t4_fetch_granted", igr > 0, 1);
      chk("t4_refused_min", refused >= MAXW, 1);
`else
      chk("t4_fetch_starved", igr, 0);
`endif
      drain();

      // 5: stray response, then reset during WAIT
      m_rvalid = 1; m_rdata = 32'hDEAD;
      cyc();
      m_rvalid = 0;
      cyc();
      chk("t5_perr", s_perr, 1);
      chk("t5_no_rvalid", s_i_rvalid | s_d_rvalid, 0);
      cyc();
      chk("t5_perr_sticky", s_perr, 1);
      i_req = 1; i_addr = 32'h200; m_ready = 1;
      cyc();
      i_req = 0;
      cyc();
      rst_n = 0; m_rvalid = 1; m_rdata = 32'hBEEF;
      mdl_reset();
      #1;
      chk("t5_rst_m_req", m_req, 0);
      chk("t5_rst_perr", proto_err, 0);
      chk("t5_rst_rdata", i_rdata, 0);
      cyc();
      rst_n = 1;
      cyc();
      m_rvalid = 0;
      cyc();
      chk("t5_dropped", s_i_rvalid, 0);
      chk("t5_late_perr", s_perr, 1);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         if (last_ig || !i_req) begin
            i_req  = ($urandom_range(0, 2) == 0);
            i_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (last_dg || !d_req) begin
            d_req   = ($urandom_range(0, 2) == 0);
            d_we    = $urandom_range(0, 1);
            d_size  = 3'($urandom_range(0, 7));
            d_addr  = $urandom;
            d_wdata = $urandom;
         end
         m_ready  = $urandom_range(0, 1);
         m_rvalid = t_busy && t_acc && ($urandom_range(0, 2) != 0);
         m_rdata  = $urandom;
         cyc();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
